// File: rtl/map_query_arbiter_if.sv
// Request, response and map-memory signals of map_query_arbiter.
// slave = arbiter side; master = requesters plus map memory.
interface map_query_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]    req;
    logic [10*N_REQ-1:0] req_r;
    logic [10*N_REQ-1:0] req_c;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rsp_valid;
    logic [2:0]          rsp_type;
    logic [9:0]          map_r;
    logic [9:0]          map_c;
    logic [2:0]          map_type;
    logic                busy;

    modport master (
        output req, req_r, req_c, map_type,
        input  gnt, rsp_valid, rsp_type, map_r, map_c, busy
    );

    modport slave (
        input  req, req_r, req_c, map_type,
        output gnt, rsp_valid, rsp_type, map_r, map_c, busy
    );
endinterface

// File: rtl/map_query_arbiter.sv
// Serializes player/monster map-tile lookups round-robin onto the single map read port.
// Build macro MAP_ARB_PLAYER_PRIORITY_EN gives requester 0 (player) absolute priority.
module map_query_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAP_LAT  = 2,
    parameter int MAP_ROWS = 15,
    parameter int MAP_COLS = 20
) (
    input  logic               clk_13,
    input  logic               rst,
    map_query_arbiter_if.slave bus
);

    localparam int               IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int               CNT_W     = $clog2(MAP_LAT + 1);
    localparam logic [9:0]       ROW_LIM   = 10'(MAP_ROWS);
    localparam logic [9:0]       COL_LIM   = 10'(MAP_COLS);
    localparam logic [2:0]       TILE_WALL = 3'b010;
    localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] cur, cur_n;
    logic [N_REQ-1:0] gnt, gnt_n;
    logic [N_REQ-1:0] rsp_valid, rsp_valid_n;
    logic [2:0]       rsp_type, rsp_type_n;
    logic [9:0]       map_r, map_r_n;
    logic [9:0]       map_c, map_c_n;
    logic             busy, busy_n;

    logic             any_req;
    logic [IDX_W-1:0] win;
    logic [9:0]       win_r, win_c;
    logic             win_ok;

    // Rotating scan that starts just after the previous winner.
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        win   = ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && bus.req[idx]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
`ifdef MAP_ARB_PLAYER_PRIORITY_EN
        if (bus.req[0]) win = '0;
`endif
    end

    assign any_req = |bus.req;
    assign win_r   = bus.req_r[10*int'(win) +: 10];
    assign win_c   = bus.req_c[10*int'(win) +: 10];
    assign win_ok  = (win_r < ROW_LIM) && (win_c < COL_LIM);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        ptr_n       = ptr;
        cur_n       = cur;
        gnt_n       = '0;
        rsp_valid_n = '0;
        rsp_type_n  = rsp_type;
        map_r_n     = map_r;
        map_c_n     = map_c;
        busy_n      = busy;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_n[win] = 1'b1;
                    ptr_n      = win;
                    cur_n      = win;
                    busy_n     = 1'b1;
                    if (win_ok) begin
                        map_r_n = win_r;
                        map_c_n = win_c;
                        cnt_n   = CNT_W'(MAP_LAT);
                        state_n = WAIT;
                    end else begin
                        // Off-map coordinates read as wall without touching memory.
                        rsp_type_n       = TILE_WALL;
                        rsp_valid_n[win] = 1'b1;
                        state_n          = RESPOND;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    rsp_type_n       = bus.map_type;
                    rsp_valid_n[cur] = 1'b1;
                    state_n          = RESPOND;
                end
            end
            RESPOND: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk_13 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= PTR_RST;
            cur       <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_type  <= TILE_WALL;
            map_r     <= '0;
            map_c     <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
            cur       <= cur_n;
            gnt       <= gnt_n;
            rsp_valid <= rsp_valid_n;
            rsp_type  <= rsp_type_n;
            map_r     <= map_r_n;
            map_c     <= map_c_n;
            busy      <= busy_n;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_type  = rsp_type;
    assign bus.map_r     = map_r;
    assign bus.map_c     = map_c;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_map_query_arbiter.sv
// Self-checking bench for map_query_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration order and response timing.
module tb_map_query_arbiter;

    localparam int N_REQ    = 4;
    localparam int MAP_LAT  = 2;
    localparam int MAP_ROWS = 15;
    localparam int MAP_COLS = 20;

    logic clk_13 = 1'b0;
    logic rst    = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    int         m_ptr   = N_REQ - 1;
    logic [9:0] m_map_r = '0;
    logic [9:0] m_map_c = '0;
    logic [2:0] tile [MAP_ROWS][MAP_COLS];
    logic [9:0] co_r [N_REQ];
    logic [9:0] co_c [N_REQ];

    map_query_arbiter_if #(.N_REQ(N_REQ)) bus ();

    map_query_arbiter #(
        .N_REQ   (N_REQ),
        .MAP_LAT (MAP_LAT),
        .MAP_ROWS(MAP_ROWS),
        .MAP_COLS(MAP_COLS)
    ) dut (
        .clk_13(clk_13),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_13 = ~clk_13;
    always @(posedge clk_13) cyc <= cyc + 1;

    // Map ROM with one output register: data for a new address is ready two edges later.
    always @(posedge clk_13) begin
        if (int'(bus.map_r) < MAP_ROWS && int'(bus.map_c) < MAP_COLS)
            bus.map_type <= tile[int'(bus.map_r)][int'(bus.map_c)];
        else
            bus.map_type <= 3'b111;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_13);
        @(negedge clk_13);
    endtask

    task automatic set_req(input int i, input logic [9:0] r, input logic [9:0] c);
        co_r[i] = r;
        co_c[i] = c;
        bus.req_r[10*i +: 10] = r;
        bus.req_c[10*i +: 10] = c;
        bus.req[i] = 1'b1;
    endtask

    task automatic wait_gnt(input int budget, output logic [N_REQ-1:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.gnt != '0) begin
                g  = bus.gnt;
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [N_REQ-1:0] onehot(input int w);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    function automatic bit in_range(input logic [9:0] r, input logic [9:0] c);
        return (int'(r) < MAP_ROWS) && (int'(c) < MAP_COLS);
    endfunction

    // Reference arbitration: first requester after the last winner, wrapping around.
    function automatic int model_winner(input logic [N_REQ-1:0] rq, input int p);
`ifdef MAP_ARB_PLAYER_PRIORITY_EN
        if (rq[0]) return 0;
`endif
        for (int k = 1; k <= N_REQ; k++)
            if (rq[(p + k) % N_REQ]) return (p + k) % N_REQ;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_13);
        checks++;
        if ({bus.gnt, bus.rsp_valid, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_pulses: got gnt=%b rsp_valid=%b busy=%b want all 0",
                     bus.gnt, bus.rsp_valid, bus.busy);
        end
        checks++;
        if (bus.rsp_type !== 3'b010) begin
            errors++;
            $display("FAIL reset_rsp_type: got %b want 010", bus.rsp_type);
        end
        checks++;
        if ({bus.map_r, bus.map_c} !== 20'd0) begin
            errors++;
            $display("FAIL reset_map_addr: got r=%0d c=%0d want 0,0", bus.map_r, bus.map_c);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.gnt, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got gnt=%b busy=%b want 0", bus.gnt, bus.busy);
        end
        m_ptr = N_REQ - 1;
    endtask

    task automatic test_fairness();
        logic [N_REQ-1:0] g;
        bit ok;
        int w;
        int last_cyc;
        last_cyc = 0;
        set_req(0, 10'd1, 10'd1);
        set_req(1, 10'd2, 10'd2);
        for (int i = 0; i < 4; i++) begin
            w = model_winner(bus.req, m_ptr);
            wait_gnt(10, g, ok);
            checks++;
            if (!ok || g !== onehot(w)) begin
                errors++;
                $display("FAIL fair_gnt[%0d]: got %b want %b (ok=%0d)", i, g, onehot(w), ok);
            end
            if (i > 0) begin
                checks++;
                if (cyc - last_cyc != 4) begin
                    errors++;
                    $display("FAIL fair_spacing[%0d]: got %0d cycles want 4", i, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            m_ptr    = w;
            m_map_r  = co_r[w];
            m_map_c  = co_c[w];
            for (int t = 0; t < 5; t++) begin
                tick();
                if (bus.rsp_valid != '0) break;
            end
            checks++;
            if (bus.rsp_valid !== onehot(w)) begin
                errors++;
                $display("FAIL fair_rsp[%0d]: got %b want %b", i, bus.rsp_valid, onehot(w));
            end
            bus.req[w] = 1'b0;
            tick();
            bus.req[w] = 1'b1;
        end
        bus.req = '0;
        repeat (4) tick();
    endtask

    task automatic test_basic();
        int w;
        logic [9:0] r, c;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 0 : 3;
            r = (k == 0) ? 10'd3 : 10'd14;
            c = (k == 0) ? 10'd2 : 10'd19;
            set_req(w, r, c);
            tick();
            checks++;
            if (bus.gnt !== onehot(w)) begin
                errors++;
                $display("FAIL basic_gnt[%0d]: got %b want %b", k, bus.gnt, onehot(w));
            end
            checks++;
            if ({bus.map_r, bus.map_c, bus.busy, bus.rsp_valid} !== {r, c, 1'b1, 4'b0}) begin
                errors++;
                $display("FAIL basic_addr[%0d]: got r=%0d c=%0d busy=%b rsp=%b want r=%0d c=%0d busy=1 rsp=0",
                         k, bus.map_r, bus.map_c, bus.busy, bus.rsp_valid, r, c);
            end
            m_ptr   = w;
            m_map_r = r;
            m_map_c = c;
            tick();
            checks++;
            if ({bus.gnt, bus.rsp_valid} !== '0) begin
                errors++;
                $display("FAIL basic_wait[%0d]: got gnt=%b rsp=%b want 0", k, bus.gnt, bus.rsp_valid);
            end
            tick();
            checks++;
            if (bus.rsp_valid !== onehot(w) || bus.rsp_type !== tile[int'(r)][int'(c)]) begin
                errors++;
                $display("FAIL basic_rsp[%0d]: got rsp=%b type=%b want rsp=%b type=%b",
                         k, bus.rsp_valid, bus.rsp_type, onehot(w), tile[int'(r)][int'(c)]);
            end
            bus.req[w] = 1'b0;
            tick();
            checks++;
            if ({bus.busy, bus.rsp_valid} !== '0) begin
                errors++;
                $display("FAIL basic_done[%0d]: got busy=%b rsp=%b want 0", k, bus.busy, bus.rsp_valid);
            end
        end
    endtask

    task automatic test_out_of_range();
        int w;
        logic [9:0] r, c;
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 2 : ((k == 1) ? 3 : 1);
            r = (k == 0) ? 10'd15 : ((k == 1) ? 10'd14 : 10'd1023);
            c = (k == 0) ? 10'd0 : ((k == 1) ? 10'd20 : 10'd5);
            set_req(w, r, c);
            tick();
            checks++;
            if (bus.gnt !== onehot(w) || bus.rsp_valid !== onehot(w)) begin
                errors++;
                $display("FAIL oor_gnt_rsp[%0d]: got gnt=%b rsp=%b want both %b",
                         k, bus.gnt, bus.rsp_valid, onehot(w));
            end
            checks++;
            if (bus.rsp_type !== 3'b010) begin
                errors++;
                $display("FAIL oor_type[%0d]: got %b want 010", k, bus.rsp_type);
            end
            checks++;
            if ({bus.map_r, bus.map_c} !== {m_map_r, m_map_c}) begin
                errors++;
                $display("FAIL oor_map_hold[%0d]: got r=%0d c=%0d want r=%0d c=%0d",
                         k, bus.map_r, bus.map_c, m_map_r, m_map_c);
            end
            m_ptr = w;
            bus.req[w] = 1'b0;
            tick();
            checks++;
            if ({bus.gnt, bus.rsp_valid, bus.busy} !== '0) begin
                errors++;
                $display("FAIL oor_done[%0d]: got gnt=%b rsp=%b busy=%b want 0",
                         k, bus.gnt, bus.rsp_valid, bus.busy);
            end
        end
    endtask

    task automatic test_withdrawn();
        set_req(1, 10'd5, 10'd7);
        tick();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL wd_gnt: got %b want 0010", bus.gnt);
        end
        m_ptr   = 1;
        m_map_r = 10'd5;
        m_map_c = 10'd7;
        bus.req[1] = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_type !== tile[5][7]) begin
            errors++;
            $display("FAIL wd_rsp: got rsp=%b type=%b want rsp=0010 type=%b",
                     bus.rsp_valid, bus.rsp_type, tile[5][7]);
        end
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (bus.gnt !== '0) begin
                errors++;
                $display("FAIL wd_no_regrant[%0d]: got gnt=%b want 0000", t, bus.gnt);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int w;
        set_req(1, 10'd6, 10'd6);
        tick();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL rmf_gnt: got %b want 0010", bus.gnt);
        end
        @(posedge clk_13);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.gnt, bus.rsp_valid, bus.busy, bus.rsp_type, bus.map_r, bus.map_c}
            !== {4'b0, 4'b0, 1'b0, 3'b010, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL rmf_async: got gnt=%b rsp=%b busy=%b type=%b r=%0d c=%0d want reset values",
                     bus.gnt, bus.rsp_valid, bus.busy, bus.rsp_type, bus.map_r, bus.map_c);
        end
        bus.req[1] = 1'b0;
        @(negedge clk_13);
        tick();
        rst = 1'b0;
        m_ptr   = N_REQ - 1;
        m_map_r = '0;
        m_map_c = '0;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if (bus.rsp_valid !== '0) begin
                errors++;
                $display("FAIL rmf_no_rsp[%0d]: got %b want 0000", t, bus.rsp_valid);
            end
        end
        set_req(0, 10'd2, 10'd3);
        set_req(2, 10'd4, 10'd4);
        w = model_winner(bus.req, m_ptr);
        tick();
        checks++;
        if (bus.gnt !== onehot(w)) begin
            errors++;
            $display("FAIL rmf_ptr_reset: got %b want %b", bus.gnt, onehot(w));
        end
        m_ptr   = w;
        m_map_r = co_r[w];
        m_map_c = co_c[w];
        bus.req = '0;
        repeat (4) tick();
    endtask

    task automatic test_priority();
        logic [N_REQ-1:0] g;
        bit ok;
        int w;
        set_req(0, 10'd3, 10'd2);
        set_req(2, 10'd14, 10'd19);
        for (int i = 0; i < 4; i++) begin
            w = model_winner(bus.req, m_ptr);
            wait_gnt(8, g, ok);
            checks++;
            if (!ok || g !== onehot(w)) begin
                errors++;
                $display("FAIL prio_gnt[%0d]: got %b want %b (ok=%0d)", i, g, onehot(w), ok);
            end
            m_ptr   = w;
            m_map_r = co_r[w];
            m_map_c = co_c[w];
        end
        bus.req = '0;
        repeat (4) tick();
    endtask

    task automatic test_random();
        int w;
        logic [9:0] r, c;
        for (int i = 0; i < N_REQ; i++)
            if ($urandom_range(0, 1) == 1)
                set_req(i, 10'($urandom_range(0, 16)), 10'($urandom_range(0, 21)));
        if (bus.req == '0) set_req(0, 10'd7, 10'd7);
        for (int n = 0; n < 40; n++) begin
            w = model_winner(bus.req, m_ptr);
            r = co_r[w];
            c = co_c[w];
            tick();
            checks++;
            if (bus.gnt !== onehot(w)) begin
                errors++;
                $display("FAIL rand_gnt[%0d]: got %b want %b req=%b", n, bus.gnt, onehot(w), bus.req);
            end
            m_ptr = w;
            bus.req_r[10*w +: 10] = 10'($urandom);
            bus.req_c[10*w +: 10] = 10'($urandom);
            if (in_range(r, c)) begin
                checks++;
                if ({bus.map_r, bus.map_c, bus.rsp_valid} !== {r, c, 4'b0}) begin
                    errors++;
                    $display("FAIL rand_addr[%0d]: got r=%0d c=%0d rsp=%b want r=%0d c=%0d rsp=0000",
                             n, bus.map_r, bus.map_c, bus.rsp_valid, r, c);
                end
                m_map_r = r;
                m_map_c = c;
                repeat (MAP_LAT) tick();
                checks++;
                if (bus.rsp_valid !== onehot(w) || bus.rsp_type !== tile[int'(r)][int'(c)]) begin
                    errors++;
                    $display("FAIL rand_rsp[%0d]: got rsp=%b type=%b want rsp=%b type=%b",
                             n, bus.rsp_valid, bus.rsp_type, onehot(w), tile[int'(r)][int'(c)]);
                end
            end else begin
                checks++;
                if (bus.rsp_valid !== onehot(w) || bus.rsp_type !== 3'b010 ||
                    {bus.map_r, bus.map_c} !== {m_map_r, m_map_c}) begin
                    errors++;
                    $display("FAIL rand_oor[%0d]: got rsp=%b type=%b r=%0d c=%0d want rsp=%b type=010 r=%0d c=%0d",
                             n, bus.rsp_valid, bus.rsp_type, bus.map_r, bus.map_c,
                             onehot(w), m_map_r, m_map_c);
                end
            end
            bus.req[w] = 1'b0;
            tick();
            checks++;
            if ({bus.gnt, bus.rsp_valid, bus.busy} !== '0) begin
                errors++;
                $display("FAIL rand_idle[%0d]: got gnt=%b rsp=%b busy=%b want 0",
                         n, bus.gnt, bus.rsp_valid, bus.busy);
            end
            for (int i = 0; i < N_REQ; i++)
                if (!bus.req[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 10'($urandom_range(0, 16)), 10'($urandom_range(0, 21)));
            if (bus.req == '0)
                set_req(int'($urandom_range(0, N_REQ - 1)), 10'($urandom_range(0, 16)),
                        10'($urandom_range(0, 21)));
        end
        bus.req = '0;
        repeat (4) tick();
    endtask

    initial begin
        bus.req   = '0;
        bus.req_r = '0;
        bus.req_c = '0;
        for (int r = 0; r < MAP_ROWS; r++)
            for (int c = 0; c < MAP_COLS; c++)
                tile[r][c] = 3'($urandom);
        tile[3][2]   = 3'b001;
        tile[14][19] = 3'b101;
        tile[5][7]   = 3'b011;
        #1;
        test_reset();
        test_fairness();
        test_basic();
        test_out_of_range();
        test_withdrawn();
        test_reset_midflight();
        test_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
